// File: rtl/master_spi.sv
// SPI mode-0 master, MSB first: one byte per accepted request, Done_o pulses when the byte ends.
// Latency: CS_o falls one cycle after the accept. Done_o comes 17*HALF cycles later with Hold_i=1, or 18*HALF with Hold_i=0. Requests are ignored while Busy_o=1.
module master_spi #(
   parameter int CLOCK_HZ = 25_000_000,
   parameter int SPI_HZ   = 1_000_000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Request_i,
   input  logic [7:0] Data_i,
   input  logic       Hold_i,
   output logic       Busy_o,
   output logic       Done_o,
   output logic [7:0] DataReceived_o,
   output logic       CS_o,
   output logic       SCK_o,
   output logic       MOSI_o,
   input  logic       MISO_i
);

   localparam int HALF_RAW = CLOCK_HZ / (2 * SPI_HZ);
   localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
   localparam int CW       = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

   typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

   state_t        r_state;
   logic [CW-1:0] r_half_cnt;
   logic [2:0]    r_bit_cnt;
   logic [7:0]    r_tx;
   logic [7:0]    r_rx;
   logic [7:0]    r_data_rx;
   logic          r_busy;
   logic          r_done;
   logic          r_cs;
   logic          r_sck;
   logic          r_mosi;
   logic          w_half_done;

   assign w_half_done    = (r_half_cnt == HALF_LAST);
   assign Busy_o         = r_busy;
   assign Done_o         = r_done;
   assign DataReceived_o = r_data_rx;
   assign CS_o           = r_cs;
   assign SCK_o          = r_sck;
   assign MOSI_o         = r_mosi;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state    <= IDLE;
         r_half_cnt <= '0;
         r_bit_cnt  <= '0;
         r_tx       <= '0;
         r_rx       <= '0;
         r_data_rx  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_cs       <= 1'b1;
         r_sck      <= 1'b0;
         r_mosi     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               // CS_o is left alone here so a held chip select survives between bytes.
               if (Request_i) begin
                  r_tx       <= Data_i;
                  r_mosi     <= Data_i[7];
                  r_cs       <= 1'b0;
                  r_sck      <= 1'b0;
                  r_busy     <= 1'b1;
                  r_half_cnt <= '0;
                  r_bit_cnt  <= '0;
                  r_state    <= SETUP;
               end
            end
            SETUP: begin
               if (w_half_done) begin
                  r_half_cnt <= '0;
                  r_sck      <= 1'b1;
                  r_rx       <= {r_rx[6:0], MISO_i};
                  r_state    <= HIGH;
               end else begin
                  r_half_cnt <= r_half_cnt + CW'(1);
               end
            end
            HIGH: begin
               if (w_half_done) begin
                  r_half_cnt <= '0;
                  r_sck      <= 1'b0;
                  r_state    <= LOW;
                  // After the last bit MOSI_o keeps bit 0 until the next byte.
                  if (r_bit_cnt != 3'd7) begin
                     r_tx   <= {r_tx[6:0], 1'b0};
                     r_mosi <= r_tx[6];
                  end
               end else begin
                  r_half_cnt <= r_half_cnt + CW'(1);
               end
            end
            LOW: begin
               if (w_half_done) begin
                  r_half_cnt <= '0;
                  if (r_bit_cnt == 3'd7) begin
                     r_bit_cnt <= '0;
                     if (Hold_i) begin
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_data_rx <= r_rx;
                        r_state   <= IDLE;
                     end else begin
                        r_cs    <= 1'b1;
                        r_state <= GAP;
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     r_sck     <= 1'b1;
                     r_rx      <= {r_rx[6:0], MISO_i};
                     r_state   <= HIGH;
                  end
               end else begin
                  r_half_cnt <= r_half_cnt + CW'(1);
               end
            end
            GAP: begin
               if (w_half_done) begin
                  r_half_cnt <= '0;
                  r_done     <= 1'b1;
                  r_busy     <= 1'b0;
                  r_data_rx  <= r_rx;
                  r_state    <= IDLE;
               end else begin
                  r_half_cnt <= r_half_cnt + CW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_master_spi.sv
// Directed bench for master_spi at HALF=2, with a behavioural mode-0 slave capturing MOSI bytes.
module tb_master_spi;
   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       Request_i = 1'b0;
   logic       Hold_i = 1'b0;
   logic [7:0] Data_i = 8'h00;
   logic       Busy_o, Done_o, CS_o, SCK_o, MOSI_o, MISO_i;
   logic [7:0] DataReceived_o;
   logic       loop_en = 1'b0;
   logic       miso_val = 1'b0;

   assign MISO_i = loop_en ? MOSI_o : miso_val;

   master_spi #(.CLOCK_HZ(8), .SPI_HZ(2)) dut (
      .Clock(Clock), .Reset(Reset), .Request_i(Request_i), .Data_i(Data_i),
      .Hold_i(Hold_i), .Busy_o(Busy_o), .Done_o(Done_o),
      .DataReceived_o(DataReceived_o), .CS_o(CS_o), .SCK_o(SCK_o),
      .MOSI_o(MOSI_o), .MISO_i(MISO_i)
   );

   always #5 Clock = ~Clock;

   // Behavioural slave: shifts MOSI on SCK rises while selected, one entry per 8 bits.
   logic [7:0] sl_sh = 8'h00;
   int         sl_bits = 0;
   int         sl_n = 0;
   logic [7:0] sl_bytes [0:15];
   always @(posedge SCK_o or posedge CS_o) begin
      if (CS_o === 1'b1) begin
         sl_bits = 0;
      end else begin
         sl_sh = {sl_sh[6:0], MOSI_o};
         sl_bits++;
         if (sl_bits == 8) begin
            if (sl_n < 16) sl_bytes[sl_n] = sl_sh;
            sl_n++;
            sl_bits = 0;
         end
      end
   end

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int start = 0;
   int rises, done_cnt, done_cyc, first_rise, cs_first_low, cs_last_low, sck_cs_err, csh;
   logic [7:0] mosi_bits;
   logic prev_sck = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      rises = 0; done_cnt = 0; done_cyc = -1; first_rise = -1;
      cs_first_low = -1; cs_last_low = -1; sck_cs_err = 0; csh = 0;
      mosi_bits = 8'h00;
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
      cyc++;
      if (SCK_o === 1'b1 && prev_sck === 1'b0) begin
         rises++;
         if (rises == 1) first_rise = cyc;
         mosi_bits = {mosi_bits[6:0], MOSI_o};
      end
      prev_sck = SCK_o;
      if (Done_o === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (CS_o === 1'b0) begin
         if (cs_first_low < 0) cs_first_low = cyc;
         cs_last_low = cyc;
      end else begin
         csh++;
      end
      if (SCK_o === 1'b1 && CS_o === 1'b1) sck_cs_err++;
   endtask

   task automatic send(input logic [7:0] d, input logic h);
      Request_i = 1'b1;
      Data_i    = d;
      Hold_i    = h;
      start     = cyc;
      tick();
      Request_i = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int d0;
      int n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < 100) begin
         tick();
         n++;
      end
      chk(tag, (done_cnt != d0) ? 32'd1 : 32'd0, 32'd1);
   endtask

   initial begin
      int base;
      int n;
      clr();

      // Reset and idle
      repeat (3) tick();
      Reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_outputs", {CS_o, SCK_o, MOSI_o, Busy_o, Done_o, DataReceived_o}, 13'h1000);
      end

      // Loopback 0xA5, Hold_i=0
      clr();
      loop_en = 1'b1;
      send(8'hA5, 1'b0);
      Data_i = 8'h00;
      chk("accept_busy", Busy_o, 1'b1);
      chk("accept_cs", CS_o, 1'b0);
      chk("accept_mosi", MOSI_o, 1'b1);
      wait_done("loop_done_seen");
      chk("loop_done_cycle", done_cyc - start, 37);
      chk("loop_rx", DataReceived_o, 8'hA5);
      chk("loop_busy_at_done", Busy_o, 1'b0);
      chk("loop_rises", rises, 8);
      chk("loop_mosi_bits", mosi_bits, 8'hA5);
      chk("loop_first_rise", first_rise - start, 3);
      chk("loop_cs_first_low", cs_first_low - start, 1);
      chk("loop_cs_last_low", cs_last_low - start, 34);
      repeat (5) tick();
      chk("loop_one_done", done_cnt, 1);
      chk("loop_mosi_hold_bit0", MOSI_o, 1'b1);
      chk("loop_sck_vs_cs", sck_cs_err, 0);

      // Hold chain into the slave model
      loop_en  = 1'b0;
      miso_val = 1'b0;
      base = sl_n;
      clr();
      send(8'h01, 1'b1);
      wait_done("chain0_done_seen");
      chk("chain0_done_cycle", done_cyc - start, 35);
      send(8'h03, 1'b1);
      chk("chain1_accept_busy", Busy_o, 1'b1);
      wait_done("chain1_done_seen");
      send(8'h07, 1'b1);
      wait_done("chain2_done_seen");
      send(8'h0F, 1'b0);
      wait_done("chain3_done_seen");
      chk("chain_cs_high_cycles", csh, 3);
      chk("chain_slave_count", sl_n - base, 4);
      chk("chain_byte0", sl_bytes[base], 8'h01);
      chk("chain_byte1", sl_bytes[base + 1], 8'h03);
      chk("chain_byte2", sl_bytes[base + 2], 8'h07);
      chk("chain_byte3", sl_bytes[base + 3], 8'h0F);
      chk("chain_rises", rises, 32);

      // Busy rejection
      clr();
      loop_en = 1'b1;
      send(8'h3C, 1'b0);
      while (cyc < start + 9) tick();
      Request_i = 1'b1;
      Data_i    = 8'hFF;
      tick();
      Request_i = 1'b0;
      chk("reject_still_busy", Busy_o, 1'b1);
      wait_done("reject_done_seen");
      chk("reject_rx", DataReceived_o, 8'h3C);
      chk("reject_mosi_bits", mosi_bits, 8'h3C);
      repeat (40) tick();
      chk("reject_one_done", done_cnt, 1);
      chk("reject_idle_busy", Busy_o, 1'b0);

      // Reset mid-transfer
      clr();
      send(8'h55, 1'b0);
      n = 0;
      while (rises < 3 && n < 100) begin
         tick();
         n++;
      end
      chk("midreset_reached_3_rises", rises, 3);
      Reset = 1'b1;
      tick();
      chk("midreset_outputs", {CS_o, SCK_o, Busy_o, Done_o, DataReceived_o}, 12'h800);
      Reset = 1'b0;
      repeat (10) tick();
      chk("midreset_no_done", done_cnt, 0);
      clr();
      send(8'h81, 1'b0);
      wait_done("after_reset_done_seen");
      chk("after_reset_rx", DataReceived_o, 8'h81);
      chk("after_reset_mosi_bits", mosi_bits, 8'h81);
      chk("after_reset_rises", rises, 8);

      // Constant MISO
      loop_en  = 1'b0;
      miso_val = 1'b1;
      send(8'h00, 1'b0);
      wait_done("miso1_done_seen");
      chk("miso1_rx", DataReceived_o, 8'hFF);
      miso_val = 1'b0;
      send(8'hFF, 1'b0);
      wait_done("miso0_done_seen");
      chk("miso0_rx", DataReceived_o, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "simulation time limit");
   end

endmodule
